// File: rtl/soc_system_pll_supervisor.sv
`default_nettype none
// ============================================================================
//  Module      : soc_system_pll_supervisor
//  Description : Sequences PLL reset, waits for a stable lock and then releases
//                the downstream system reset. Retries a bounded number of
//                times before latching a fault. Optional macro
//                PLL_SUPERVISOR_LOSS_CNT_EN adds a saturating lock-loss counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_system_pll_supervisor #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 7
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       lock_ok,
    output logic       fault,
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
    output logic [7:0] loss_cnt,
`endif
    output logic [3:0] retry_cnt
);

    // Counter is sized from the largest cycle parameter; it only ever needs
    // to reach (parameter - 1) and saturates rather than wrapping.
    localparam int c_CNT_MAX_A = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                                 RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
    localparam int c_CNT_MAX   = (c_CNT_MAX_A > LOCK_TIMEOUT_CYCLES) ?
                                 c_CNT_MAX_A : LOCK_TIMEOUT_CYCLES;
    localparam int c_CNT_W     = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_RST_LAST     = c_CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_STABLE_LAST  = c_CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT      = {c_CNT_W{1'b1}};
    localparam logic [c_CNT_W-1:0] c_CNT_ONE      = c_CNT_W'(1);
    localparam logic [3:0]         c_MAX_RETRIES  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [c_CNT_W-1:0]   w_cnt_inc;
    logic [3:0]           r_retry;
    logic [3:0]           w_retry_nxt;
    logic [1:0]           r_sync;
    logic                 w_locked_s;
    logic                 w_fail_evt;
    // Set by rst so the edge that releases reset does not count toward the
    // PLL reset pulse; the pulse therefore spans the first N edges after rst.
    logic                 r_pulse_hold;

    logic                 r_pll_rst;
    logic                 r_sys_rst;
    logic                 r_lock_ok;
    logic                 r_fault;
    logic                 w_pll_rst_nxt;
    logic                 w_sys_rst_nxt;
    logic                 w_lock_ok_nxt;
    logic                 w_fault_nxt;

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], pll_locked};
        end
    end

    assign w_locked_s = r_sync[1];
    assign w_cnt_inc  = (r_cnt == c_CNT_SAT) ? r_cnt : (r_cnt + c_CNT_ONE);

    // Next-state, counter and retry logic; relock_req overrides lock/timeout events.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_retry_nxt = r_retry;
        w_fail_evt  = 1'b0;

        if (relock_req) begin
            w_state_nxt = ST_PLL_RST;
            if (r_state == ST_FAULT) begin
                w_retry_nxt = 4'd0;
            end
        end else begin
            case (r_state)
                ST_PLL_RST: begin
                    if (!r_pulse_hold) begin
                        if (r_cnt == c_RST_LAST) begin
                            w_state_nxt = ST_WAIT_LOCK;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_locked_s) begin
                        w_state_nxt = ST_STABLE;
                    end else if (r_cnt == c_TIMEOUT_LAST) begin
                        w_fail_evt = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                ST_STABLE: begin
                    if (!w_locked_s) begin
                        w_fail_evt = 1'b1;
                    end else if (r_cnt == c_STABLE_LAST) begin
                        w_state_nxt = ST_RUN;
                        w_retry_nxt = 4'd0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                ST_RUN: begin
                    // Loss of lock in RUN is not a retry; just re-initialise.
                    if (!w_locked_s) begin
                        w_state_nxt = ST_PLL_RST;
                    end
                end
                ST_FAULT: begin
                    w_state_nxt = ST_FAULT;
                end
                default: begin
                    w_state_nxt = ST_PLL_RST;
                end
            endcase

            if (w_fail_evt) begin
                if (r_retry < c_MAX_RETRIES) begin
                    w_retry_nxt = r_retry + 4'd1;
                    w_state_nxt = ST_PLL_RST;
                end else begin
                    w_state_nxt = ST_FAULT;
                end
            end
        end

        // Shared counter restarts on every state change and on relock.
        if ((w_state_nxt != r_state) || relock_req) begin
            w_cnt_nxt = '0;
        end
    end

    // Outputs are decoded from the next state so they change with the state register.
    assign w_pll_rst_nxt = (w_state_nxt == ST_PLL_RST) || (w_state_nxt == ST_FAULT);
    assign w_sys_rst_nxt = (w_state_nxt != ST_RUN);
    assign w_lock_ok_nxt = (w_state_nxt == ST_RUN);
    assign w_fault_nxt   = (w_state_nxt == ST_FAULT);

    // State, counter, retry and registered output update.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state      <= ST_PLL_RST;
            r_cnt        <= '0;
            r_retry      <= 4'd0;
            r_pulse_hold <= 1'b1;
            r_pll_rst    <= 1'b1;
            r_sys_rst    <= 1'b1;
            r_lock_ok    <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_retry      <= w_retry_nxt;
            r_pulse_hold <= 1'b0;
            r_pll_rst    <= w_pll_rst_nxt;
            r_sys_rst    <= w_sys_rst_nxt;
            r_lock_ok    <= w_lock_ok_nxt;
            r_fault      <= w_fault_nxt;
        end
    end

    assign pll_rst   = r_pll_rst;
    assign sys_rst   = r_sys_rst;
    assign lock_ok   = r_lock_ok;
    assign fault     = r_fault;
    assign retry_cnt = r_retry;

`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
    logic [7:0] r_loss_cnt;
    logic       w_loss_evt;

    // A lock-loss exit from RUN; a simultaneous relock request is not a loss.
    assign w_loss_evt = (r_state == ST_RUN) && !w_locked_s && !relock_req;

    // Saturating lock-loss counter, cleared only by rst.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_loss_cnt <= 8'd0;
        end else if (w_loss_evt && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign loss_cnt = r_loss_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_soc_system_pll_supervisor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_soc_system_pll_supervisor
//  Description : Self-checking bench for soc_system_pll_supervisor using a
//                power-up vector table plus directed multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_system_pll_supervisor;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst;
    logic       lock_ok;
    logic       fault;
    logic [3:0] retry_cnt;
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
    logic [7:0] loss_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int edge_no  = 0;

    soc_system_pll_supervisor #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .MAX_RETRIES         (2)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .lock_ok    (lock_ok),
        .fault      (fault),
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
        .loss_cnt   (loss_cnt),
`endif
        .retry_cnt  (retry_cnt)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    typedef struct packed {
        logic       rst;
        logic       locked;
        logic       relock;
        logic       e_pll_rst;
        logic       e_sys_rst;
        logic       e_lock_ok;
        logic       e_fault;
        logic [3:0] e_retry;
    } vec_t;

    vec_t vecs [0:16];

    function automatic vec_t mk(input logic r, input logic l, input logic q,
                                input logic pr, input logic sr, input logic lo,
                                input logic fa, input logic [3:0] rc);
        vec_t v;
        v.rst = r; v.locked = l; v.relock = q;
        v.e_pll_rst = pr; v.e_sys_rst = sr; v.e_lock_ok = lo;
        v.e_fault = fa; v.e_retry = rc;
        return v;
    endfunction

    task automatic step();
        @(posedge refclk);
        #1;
        edge_no++;
    endtask

    task automatic run_to(input int k);
        while (edge_no < k) step();
    endtask

    task automatic release_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
        edge_no = -1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            rst        = vecs[i].rst;
            pll_locked = vecs[i].locked;
            relock_req = vecs[i].relock;
            step();
            chk1($sformatf("vec%0d_pll_rst", i), pll_rst, vecs[i].e_pll_rst);
            chk1($sformatf("vec%0d_sys_rst", i), sys_rst, vecs[i].e_sys_rst);
            chk1($sformatf("vec%0d_lock_ok", i), lock_ok, vecs[i].e_lock_ok);
            chk1($sformatf("vec%0d_fault", i), fault, vecs[i].e_fault);
            chk4($sformatf("vec%0d_retry", i), retry_cnt, vecs[i].e_retry);
        end
    endtask

    initial begin
        // Power-up with a constantly locked PLL: row 0 is the rst edge,
        // rows 1..16 are edges 0..15 after reset release.
        vecs[0] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 1; i <= 4; i++)
            vecs[i] = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 5; i <= 13; i++)
            vecs[i] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 14; i <= 16; i++)
            vecs[i] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

        rst        = 1'b1;
        pll_locked = 1'b1;
        relock_req = 1'b0;
        step();
        step();

        // Power-up to RUN
        run_table(0, 16);

        // One-cycle lock drop while in RUN
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        step();
        chk1("drop_still_run", lock_ok, 1'b1);
        step();
        chk1("drop_sys_rst", sys_rst, 1'b1);
        chk1("drop_lock_ok", lock_ok, 1'b0);
        chk1("drop_pll_rst", pll_rst, 1'b1);
        chk4("drop_retry", retry_cnt, 4'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk1("drop_pulse", pll_rst, 1'b1);
        end
        step();
        chk1("drop_pulse_end", pll_rst, 1'b0);
        chk4("drop_retry_end", retry_cnt, 4'd0);
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
        chk8("drop_loss_cnt", loss_cnt, 8'd1);
`endif
        for (int k = 0; k < 8; k++) step();
        chk1("drop_rerun_early", lock_ok, 1'b0);
        step();
        chk1("drop_rerun", lock_ok, 1'b1);

        // rst pulse during RUN repeats the power-up timing
        run_table(0, 16);
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
        chk8("rst_loss_cnt", loss_cnt, 8'd0);
`endif

        // relock_req inside PLL_RST restarts the pulse
        pll_locked = 1'b1;
        release_rst();
        run_to(1);
        relock_req = 1'b1;
        step();
        relock_req = 1'b0;
        run_to(5);
        chk1("restart_pulse_hold", pll_rst, 1'b1);
        step();
        chk1("restart_pulse_end", pll_rst, 1'b0);

        // Glitch during STABLE: one retry, then a full fresh stable window
        release_rst();
        run_to(7);
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        step();
        chk4("stable_retry_pre", retry_cnt, 4'd0);
        step();
        chk4("stable_retry", retry_cnt, 4'd1);
        chk1("stable_pll_rst", pll_rst, 1'b1);
        chk1("stable_sys_rst", sys_rst, 1'b1);
        run_to(22);
        chk1("stable_run_early", lock_ok, 1'b0);
        step();
        chk1("stable_run", lock_ok, 1'b1);
        chk4("stable_retry_clr", retry_cnt, 4'd0);

        // No lock at all: retries exhaust into FAULT, relock recovers
        pll_locked = 1'b0;
        release_rst();
        run_to(3);
        chk1("nolock_p1_hold", pll_rst, 1'b1);
        step();
        chk1("nolock_p1_end", pll_rst, 1'b0);
        run_to(35);
        chk4("nolock_retry0", retry_cnt, 4'd0);
        step();
        chk4("nolock_retry1", retry_cnt, 4'd1);
        chk1("nolock_p2", pll_rst, 1'b1);
        run_to(39);
        chk1("nolock_p2_hold", pll_rst, 1'b1);
        step();
        chk1("nolock_p2_end", pll_rst, 1'b0);
        run_to(72);
        chk4("nolock_retry2", retry_cnt, 4'd2);
        chk1("nolock_p3", pll_rst, 1'b1);
        run_to(76);
        chk1("nolock_p3_end", pll_rst, 1'b0);
        run_to(107);
        chk1("nolock_fault_early", fault, 1'b0);
        step();
        chk1("nolock_fault", fault, 1'b1);
        chk1("nolock_fault_pll_rst", pll_rst, 1'b1);
        chk1("nolock_fault_sys_rst", sys_rst, 1'b1);
        chk4("nolock_fault_retry", retry_cnt, 4'd2);
        run_to(130);
        chk1("nolock_fault_held", fault, 1'b1);
        relock_req = 1'b1;
        step();
        relock_req = 1'b0;
        chk1("relock_fault_clr", fault, 1'b0);
        chk4("relock_retry_clr", retry_cnt, 4'd0);
        chk1("relock_pll_rst", pll_rst, 1'b1);
        for (int k = 0; k < 3; k++) step();
        chk1("relock_pulse_hold", pll_rst, 1'b1);
        step();
        chk1("relock_pulse_end", pll_rst, 1'b0);

        // relock_req on the same edge as a WAIT_LOCK timeout
        release_rst();
        run_to(35);
        relock_req = 1'b1;
        step();
        relock_req = 1'b0;
        chk4("collide_retry", retry_cnt, 4'd0);
        chk1("collide_pll_rst", pll_rst, 1'b1);
        run_to(39);
        chk1("collide_pulse_hold", pll_rst, 1'b1);
        step();
        chk1("collide_pulse_end", pll_rst, 1'b0);
        chk4("collide_retry_end", retry_cnt, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
